// File: rtl/x_pkg.sv
// Shared types and constants for the X integer pipe issue scheduler.
package x_pkg;

  localparam int unsigned LATENCY = 4;
  localparam int unsigned RW      = 5;
  localparam int unsigned DEPTH   = LATENCY + 1;
  localparam int unsigned FUW     = 2;

  localparam logic [FUW-1:0] FU_NONE = 2'd0;
  localparam logic [FUW-1:0] FU_X    = 2'd1;

  // X-pipe control word, 49 bits, field order is the decode packing order
  typedef struct packed {
    logic        selalushift;
    logic        selimregb;
    logic [3:0]  aluop;
    logic        unsig;
    logic [1:0]  shiftop;
    logic [4:0]  shiftamt;
    logic        writeov;
    logic [1:0]  immsel;
    logic [31:0] imm;
  } x_ctrl_t;

  localparam int unsigned CTRLW = $bits(x_ctrl_t);

  // One in-flight slot of the shadow pipe
  typedef struct packed {
    logic          v;
    logic          wr;
    logic [RW-1:0] rd;
  } x_shadow_t;

endpackage

// File: rtl/x_hazard_cmp.sv
// Compares one source register against every shadow-pipe slot.
module x_hazard_cmp
  import x_pkg::*;
(
  input  logic                  use_src,
  input  logic [RW-1:0]         src,
  input  x_shadow_t [DEPTH-1:0] shadow,
  output logic                  hit_c
);

  // The slot at S[LATENCY] writes the register file on the coming edge, so an
  // op entering the issue register on that same edge already reads the result.
  localparam logic [DEPTH-1:0] BLOCK_MASK = {1'b0, {LATENCY{1'b1}}};

  logic [DEPTH-1:0] match_c;

  // Per-slot address match against a live register write
  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign match_c[k] = shadow[k].v & shadow[k].wr & (shadow[k].rd == src);
  end

  // Register 0 is hardwired and never blocks
  assign hit_c = use_src & (src != '0) & (|(match_c & BLOCK_MASK));

endmodule

// File: rtl/x_issue_scheduler.sv
// Issue controller for the 4-stage X integer pipe with a shadow scoreboard.
module x_issue_scheduler
  import x_pkg::*;
#(
  parameter int unsigned SCW = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           dec_valid,
  output logic           dec_ready,
  input  logic [RW-1:0]  dec_rs,
  input  logic [RW-1:0]  dec_rt,
  input  logic           dec_uses_rs,
  input  logic           dec_uses_rt,
  input  logic [RW-1:0]  dec_regdest,
  input  logic           dec_writereg,
  input  x_ctrl_t        dec_ctrl,
  output logic [FUW-1:0] is_x_functionalunit,
  output logic [RW-1:0]  is_x_regdest,
  output logic           is_x_writereg,
  output x_ctrl_t        is_x_ctrl,
  output logic [31:0]    issued_count,
  output logic [SCW-1:0] stall_count
);

  x_shadow_t [DEPTH-1:0] shadow_q;
  x_shadow_t             s0_next_c;
  logic                  rs_hit_c;
  logic                  rt_hit_c;
  logic                  accept_c;
  logic                  stall_c;

  x_hazard_cmp u_cmp_rs (
    .use_src (dec_uses_rs),
    .src     (dec_rs),
    .shadow  (shadow_q),
    .hit_c   (rs_hit_c)
  );

  x_hazard_cmp u_cmp_rt (
    .use_src (dec_uses_rt),
    .src     (dec_rt),
    .shadow  (shadow_q),
    .hit_c   (rt_hit_c)
  );

  // Handshake: ready whenever out of reset and no source is still in flight
  assign dec_ready = ~reset & ~(rs_hit_c | rt_hit_c);
  assign accept_c  = dec_valid & dec_ready;
  assign stall_c   = dec_valid & ~dec_ready;

  // Issue-register slot contents: accepted op, or a bubble that keeps rd
  always_comb begin
    s0_next_c    = shadow_q[0];
    s0_next_c.v  = 1'b0;
    s0_next_c.wr = 1'b0;
    if (accept_c) begin
      s0_next_c.v  = 1'b1;
      s0_next_c.wr = dec_writereg;
      s0_next_c.rd = dec_regdest;
    end
  end

  // Shadow pipe advances every edge; the X pipe never back-pressures
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= {shadow_q[DEPTH-2:0], s0_next_c};
    end
  end

  // Slot 0 of the shadow is the issue register's destination half
  assign is_x_regdest  = shadow_q[0].rd;
  assign is_x_writereg = shadow_q[0].wr;

  // Issue register: unit select and control word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_x_functionalunit <= FU_NONE;
      is_x_ctrl           <= '0;
    end else if (accept_c) begin
      is_x_functionalunit <= FU_X;
      is_x_ctrl           <= dec_ctrl;
    end else begin
      is_x_functionalunit <= FU_NONE;
    end
  end

  // Issue counter wraps; stall counter saturates at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else begin
      if (accept_c) begin
        issued_count <= issued_count + 32'd1;
      end
      if (stall_c && (stall_count != {SCW{1'b1}})) begin
        stall_count <= stall_count + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_x_issue_scheduler.sv
// Self-checking bench for x_issue_scheduler against a last-write-time model.
module tb_x_issue_scheduler;
  import x_pkg::*;

  localparam int unsigned TB_SCW = 16;
  localparam int unsigned VW     = FUW + RW + 1 + CTRLW + 32 + TB_SCW;

  logic              clock;
  logic              reset;
  logic              dec_valid;
  logic              dec_ready;
  logic [RW-1:0]     dec_rs;
  logic [RW-1:0]     dec_rt;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic [RW-1:0]     dec_regdest;
  logic              dec_writereg;
  x_ctrl_t           dec_ctrl;
  logic [FUW-1:0]    is_x_functionalunit;
  logic [RW-1:0]     is_x_regdest;
  logic              is_x_writereg;
  x_ctrl_t           is_x_ctrl;
  logic [31:0]       issued_count;
  logic [TB_SCW-1:0] stall_count;

  x_issue_scheduler #(.SCW(TB_SCW)) dut (
    .clock               (clock),
    .reset               (reset),
    .dec_valid           (dec_valid),
    .dec_ready           (dec_ready),
    .dec_rs              (dec_rs),
    .dec_rt              (dec_rt),
    .dec_uses_rs         (dec_uses_rs),
    .dec_uses_rt         (dec_uses_rt),
    .dec_regdest         (dec_regdest),
    .dec_writereg        (dec_writereg),
    .dec_ctrl            (dec_ctrl),
    .is_x_functionalunit (is_x_functionalunit),
    .is_x_regdest        (is_x_regdest),
    .is_x_writereg       (is_x_writereg),
    .is_x_ctrl           (is_x_ctrl),
    .issued_count        (issued_count),
    .stall_count         (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: edge index of the most recent accepted write per register
  int                n_checks;
  int                n_fail;
  int                edge_n;
  int                last_wr [32];
  logic [FUW-1:0]    m_fu;
  logic [RW-1:0]     m_rd;
  logic              m_wr;
  x_ctrl_t           m_ctrl;
  logic [31:0]       m_issued;
  logic [TB_SCW-1:0] m_stall;
  logic              obs_ready;
  logic              exp_ready;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) last_wr[i] = -1000;
    m_fu = FU_NONE; m_rd = '0; m_wr = 1'b0; m_ctrl = '0;
    m_issued = '0; m_stall = '0;
  endfunction

  // A reader may enter the issue register LATENCY+1 edges after its last writer did
  function automatic bit blocked(input logic [RW-1:0] src, input logic use_it);
    if (!use_it || src == '0) return 1'b0;
    return (edge_n - last_wr[src]) <= int'(LATENCY);
  endfunction

  function automatic x_ctrl_t rand_ctrl();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return x_ctrl_t'(t[CTRLW-1:0]);
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {is_x_functionalunit, is_x_regdest, is_x_writereg, is_x_ctrl, issued_count, stall_count};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_fu, m_rd, m_wr, m_ctrl, m_issued, m_stall};
  endfunction

  task automatic drive(input logic v, input logic [RW-1:0] rs, input logic urs,
                       input logic [RW-1:0] rt, input logic urt,
                       input logic [RW-1:0] rd, input logic wr);
    dec_valid = v; dec_rs = rs; dec_uses_rs = urs; dec_rt = rt; dec_uses_rt = urt;
    dec_regdest = rd; dec_writereg = wr; dec_ctrl = rand_ctrl();
  endtask

  // One clock: sample ready mid-cycle, then advance the model over the edge
  task automatic cycle();
    logic acc;
    @(negedge clock);
    obs_ready = dec_ready;
    exp_ready = !reset && !blocked(dec_rs, dec_uses_rs) && !blocked(dec_rt, dec_uses_rt);
    acc = dec_valid && exp_ready;
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      if (acc) begin
        m_fu = FU_X; m_rd = dec_regdest; m_wr = dec_writereg; m_ctrl = dec_ctrl;
        m_issued = m_issued + 32'd1;
        if (dec_writereg && dec_regdest != '0) last_wr[dec_regdest] = edge_n;
      end else begin
        m_fu = FU_NONE; m_wr = 1'b0;
      end
      if (dec_valid && !exp_ready && m_stall != {TB_SCW{1'b1}}) m_stall = m_stall + TB_SCW'(1);
    end
    edge_n++;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({dec_ready, obs_vec()} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", i, {dec_ready, obs_vec()});
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (obs_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready cyc=%0d got=%b want=1", i, obs_ready);
      end
      n_checks++;
      if (obs_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset_idle_outputs cyc=%0d got=%h want=0", i, obs_vec());
      end
    end
  endtask

  task automatic test_independent();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, '0, 1'b0, '0, 1'b0, RW'(i), 1'b1);
      cycle();
      n_checks++;
      if (obs_ready !== 1'b1 || is_x_functionalunit !== FU_X) begin
        n_fail++;
        $display("FAIL indep_issue op=%0d got ready=%b fu=%0d want ready=1 fu=1", i, obs_ready, is_x_functionalunit);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL indep_outputs op=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
    n_checks++;
    if (issued_count !== 32'd3 || stall_count !== '0 || is_x_functionalunit !== FU_NONE) begin
      n_fail++;
      $display("FAIL indep_counts got issued=%0d stall=%0d fu=%0d want 3 0 0", issued_count, stall_count, is_x_functionalunit);
    end
  endtask

  task automatic test_dependency();
    int waited;
    logic [TB_SCW-1:0] base;
    drive(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1);
    cycle();
    base = m_stall;
    drive(1'b1, 5'd5, 1'b1, '0, 1'b0, 5'd9, 1'b0);
    waited = 0;
    obs_ready = 1'b0;
    while (!obs_ready && waited < 20) begin
      cycle();
      waited++;
      n_checks++;
      if (obs_ready !== exp_ready || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL dep_cycle cyc=%0d got ready=%b out=%h want ready=%b out=%h", waited, obs_ready, obs_vec(), exp_ready, exp_vec());
      end
    end
    n_checks++;
    if (waited != 5) begin
      n_fail++;
      $display("FAIL dep_accept_cycle got=%0d want=5", waited);
    end
    n_checks++;
    if (stall_count !== base + TB_SCW'(4)) begin
      n_fail++;
      $display("FAIL dep_stall_count got=%0d want=%0d", stall_count, base + TB_SCW'(4));
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
  endtask

  task automatic test_r0();
    logic [TB_SCW-1:0] base;
    base = m_stall;
    drive(1'b1, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    cycle();
    drive(1'b1, '0, 1'b0, '0, 1'b1, 5'd3, 1'b0);
    cycle();
    n_checks++;
    if (obs_ready !== 1'b1 || stall_count !== base || is_x_functionalunit !== FU_X) begin
      n_fail++;
      $display("FAIL r0_no_hazard got ready=%b stall=%0d fu=%0d want 1 %0d 1", obs_ready, stall_count, is_x_functionalunit, base);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
  endtask

  task automatic test_waw();
    int waited;
    logic [TB_SCW-1:0] base;
    base = m_stall;
    drive(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1); cycle();
    drive(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1); cycle();
    drive(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1); cycle();
    drive(1'b1, 5'd7, 1'b1, '0, 1'b0, 5'd10, 1'b1);
    waited = 0;
    obs_ready = 1'b0;
    while (!obs_ready && waited < 20) begin
      cycle();
      waited++;
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL waw_ready cyc=%0d got=%b want=%b", waited, obs_ready, exp_ready);
      end
    end
    n_checks++;
    if (waited != 5 || stall_count !== base + TB_SCW'(4)) begin
      n_fail++;
      $display("FAIL waw_accept got wait=%0d stall=%0d want 5 %0d", waited, stall_count, base + TB_SCW'(4));
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1); cycle();
    drive(1'b1, 5'd5, 1'b1, '0, 1'b0, 5'd6, 1'b1); cycle();
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre_stall got=%b want=0", obs_ready);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({dec_ready, obs_vec()} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async_clear got=%h want=0", {dec_ready, obs_vec()});
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    cycle();
    n_checks++;
    if (obs_ready !== 1'b1 || is_x_functionalunit !== FU_X || issued_count !== 32'd1 || stall_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_after got ready=%b fu=%0d issued=%0d stall=%0d want 1 1 1 0", obs_ready, is_x_functionalunit, issued_count, stall_count);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL midrst_outputs got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cycle();
      n_checks++;
      if (obs_ready !== exp_ready || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand cyc=%0d got ready=%b out=%h want ready=%b out=%h", i, obs_ready, obs_vec(), exp_ready, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int k;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    drive(1'b1, 5'd5, 1'b1, '0, 1'b0, 5'd5, 1'b1);
    k = 0;
    while (m_stall != 16'hFFFE && k < 90000) begin
      cycle();
      k++;
    end
    n_checks++;
    if (stall_count !== 16'hFFFE || stall_count !== m_stall) begin
      n_fail++;
      $display("FAIL sat_near got=%h want=fffe after %0d cycles", stall_count, k);
    end
    repeat (15) cycle();
    n_checks++;
    if (stall_count !== 16'hFFFF || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL sat_reach got=%h want=ffff", stall_count);
    end
    repeat (10) cycle();
    n_checks++;
    if (stall_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold got=%h want=ffff", stall_count);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    model_clear();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    test_reset();
    test_independent();
    test_dependency();
    test_r0();
    test_waw();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
